// File: rtl/sata_phy_align_ctrl.sv
// ALIGN burst insertion on TX after linkup, ALIGN stripping and sync-loss detection on RX.
// Latency: TX mux is combinational (0 cycles); RX path is registered (1 cycle).
// Backpressure: link_tx_ready drops while an ALIGN burst is on the wire; the link layer holds its dword.
module sata_phy_align_ctrl #(
    parameter logic [31:0] ALIGN_PRIM     = 32'h7B4A4ABC,
    parameter int          ALIGN_BURST    = 2,
    parameter int          ALIGN_INTERVAL = 256,
    parameter int          LOSS_LIMIT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        linkup,
    input  logic [31:0] oob_tx_dout,
    input  logic        oob_tx_isk,
    input  logic [31:0] link_tx_dout,
    input  logic        link_tx_isk,
    output logic        link_tx_ready,
    output logic [31:0] tx_dout,
    output logic        tx_isk,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_isk,
    input  logic        rx_byte_is_aligned,
    output logic [31:0] rx_dout,
    output logic [3:0]  rx_isk_out,
    output logic        rx_dout_valid,
    output logic        phy_ready,
    output logic        sync_lost,
    output logic [15:0] align_burst_count
);

    localparam int BCW = (ALIGN_BURST > 1) ? $clog2(ALIGN_BURST) : 1;
    localparam int ICW = (ALIGN_INTERVAL > 1) ? $clog2(ALIGN_INTERVAL) : 1;
    localparam int LCW = $clog2(LOSS_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        READY = 2'd2
    } state_t;

    state_t         state;
    logic [BCW-1:0] burst_cnt;
    logic [ICW-1:0] interval_cnt;
    logic [LCW-1:0] loss_cnt;

    logic burst_last;
    logic interval_last;
    logic loss_hit;

    assign burst_last    = (burst_cnt == BCW'(ALIGN_BURST - 1));
    assign interval_last = (interval_cnt == ICW'(ALIGN_INTERVAL - 1));
    // The LOSS_LIMIT-th consecutive unaligned cycle trips the loss
    assign loss_hit      = !rx_byte_is_aligned && (loss_cnt == LCW'(LOSS_LIMIT - 1));

    assign phy_ready     = (state == READY);
    assign link_tx_ready = (state == READY);

    // TX source select: OOB until linkup, ALIGN while not yet ready or in a burst, link data otherwise
    always_comb begin
        tx_dout = ALIGN_PRIM;
        tx_isk  = 1'b1;
        if (!linkup) begin
            tx_dout = oob_tx_dout;
            tx_isk  = oob_tx_isk;
        end else if (state == READY) begin
            tx_dout = link_tx_dout;
            tx_isk  = link_tx_isk;
        end
    end

    // Control FSM: linkup drop beats sync loss, sync loss beats the burst/interval transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            burst_cnt         <= '0;
            interval_cnt      <= '0;
            loss_cnt          <= '0;
            sync_lost         <= 1'b0;
            align_burst_count <= '0;
        end else begin
            sync_lost <= 1'b0;
            if (!linkup) begin
                state        <= IDLE;
                burst_cnt    <= '0;
                interval_cnt <= '0;
                loss_cnt     <= '0;
            end else if (state != IDLE && loss_hit) begin
                state        <= IDLE;
                burst_cnt    <= '0;
                interval_cnt <= '0;
                loss_cnt     <= '0;
                sync_lost    <= 1'b1;
            end else begin
                if (state != IDLE) begin
                    loss_cnt <= rx_byte_is_aligned ? '0 : loss_cnt + LCW'(1);
                end
                case (state)
                    IDLE: begin
                        if (rx_byte_is_aligned) begin
                            state     <= BURST;
                            burst_cnt <= '0;
                        end
                    end
                    BURST: begin
                        if (burst_last) begin
                            state             <= READY;
                            interval_cnt      <= '0;
                            align_burst_count <= align_burst_count + 16'd1;
                        end else begin
                            burst_cnt <= burst_cnt + BCW'(1);
                        end
                    end
                    READY: begin
                        if (interval_last) begin
                            state     <= BURST;
                            burst_cnt <= '0;
                        end else begin
                            interval_cnt <= interval_cnt + ICW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // RX register stage: data always passes, valid marks non-ALIGN dwords while ready and aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_dout       <= '0;
            rx_isk_out    <= '0;
            rx_dout_valid <= 1'b0;
        end else begin
            rx_dout       <= rx_din;
            rx_isk_out    <= rx_isk;
            rx_dout_valid <= phy_ready && rx_byte_is_aligned &&
                             !(rx_isk[0] && (rx_din == ALIGN_PRIM));
        end
    end

endmodule
